// File: rtl/operand_sel_pipe.sv
// N-way operand selector with a registered 2-entry skid-buffer output stage.
// Optional sticky out-of-range select flag when OPSEL_ERR_EN is defined.
module operand_sel_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    // state | meaning
    // EMPTY | nothing buffered
    // ONE   | main holds the head operand
    // TWO   | main holds the head, skid holds the next; input stalled
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] sel_val;
    logic             accept;
    logic             drain;

    // Out-of-range selects leave sel_val at zero.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_val = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q      <= sel_val;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_q <= sel_val;
                    end else if (accept) begin
                        skid_q     <= sel_val;
                        state_q    <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (drain) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_q     <= skid_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign out_data  = main_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

`ifdef OPSEL_ERR_EN
    logic sel_oor;
    logic sel_err_q;
    logic sel_err_d;

    assign sel_oor   = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
    assign sel_err_d = sel_err_q | (accept & sel_oor);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule
